// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared state encoding, line-width math and byte-merge helper for the L2 cache.
package l2_cache_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} l2_state_e;
  localparam int L2_MAX_BYTES = 128;
  localparam int L2_MAX_LINE = 8 * L2_MAX_BYTES;
  function automatic int line_bits(input int num_offset);
    return 8 * (1 << num_offset);
  endfunction
  // Callers zero-extend to the widest supported line and truncate the result.
  function automatic logic [L2_MAX_LINE-1:0] byte_merge(
    input logic [L2_MAX_LINE-1:0] old_line,
    input logic [L2_MAX_LINE-1:0] new_line,
    input logic [L2_MAX_BYTES-1:0] be
  );
    logic [L2_MAX_LINE-1:0] res;
    for (int i = 0; i < L2_MAX_BYTES; i++)
      res[8*i +: 8] = be[i] ? new_line[8*i +: 8] : old_line[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/l2_cache_if.sv
// l2_cache_if: CPU-side and memory-side line buses of the L2 cache; the cache uses the slave view.
interface l2_cache_if import l2_cache_pkg::*; #(parameter int NUM_OFFSET = 5);
  localparam int NUM_LINE = line_bits(NUM_OFFSET);
  logic                    mem_read;
  logic                    mem_write;
  logic [31:0]             mem_address;
  logic [NUM_LINE-1:0]     mem_wdata;
  logic [NUM_LINE/8-1:0]   mem_byte_enable;
  logic [NUM_LINE-1:0]     mem_rdata;
  logic                    mem_resp;
  logic                    pmem_read;
  logic                    pmem_write;
  logic [31:0]             pmem_address;
  logic [NUM_LINE-1:0]     pmem_wdata;
  logic [NUM_LINE-1:0]     pmem_rdata;
  logic                    pmem_resp;
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l2_plru_tree.sv
// l2_plru_tree: tree pseudo-LRU for one set; each node bit points toward the subtree to evict next.
module l2_plru_tree #(
  parameter int NUM_WAYS = 8,
  localparam int WW = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits,
  input  logic [WW-1:0]       access_way,
  input  logic                load,
  output logic [NUM_WAYS-2:0] next_bits,
  output logic [NUM_WAYS-1:0] victim
);
  always_comb begin
    int node;
    logic [WW-1:0] v;
    next_bits = bits;
    node = 0;
    v = '0;
    for (int l = 0; l < WW; l++) begin
      v[WW-1-l] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
      if (load) next_bits[(1 << l) - 1 + int'(access_way >> (WW - l))] = ~access_way[WW-1-l];
    end
    victim = '0;
    victim[v] = 1'b1;
  end
endmodule

// File: rtl/l2_cache_core.sv
// l2_cache_core: set-associative write-back/write-allocate L2 cache with controller.
// Optional performance counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache_core import l2_cache_pkg::*; #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_OFFSET = 5,
  parameter int NUM_INDEX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  l2_cache_if.slave   bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
);
  localparam int NUM_TAG = 32 - NUM_OFFSET - NUM_INDEX;
  localparam int NUM_LINE = line_bits(NUM_OFFSET);
  localparam int NUM_SETS = 1 << NUM_INDEX;
  localparam int NUM_BYTES = 1 << NUM_OFFSET;
  localparam int WW = $clog2(NUM_WAYS);
  l2_state_e state, next_state;
  logic [31-NUM_OFFSET:0] req_line;
  logic [NUM_LINE-1:0] req_wdata;
  logic [NUM_BYTES-1:0] req_be;
  logic req_write, refill;
  logic [WW-1:0] victim_way, hit_way, inv_way, plru_way, pick_way;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid, dirty;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru;
  logic [NUM_TAG-1:0] tags [NUM_SETS][NUM_WAYS];
  logic [NUM_LINE-1:0] lines [NUM_SETS][NUM_WAYS];
  logic [NUM_INDEX-1:0] set;
  logic [NUM_TAG-1:0] req_tag;
  logic [NUM_WAYS-1:0] hit_vec, plru_oh;
  logic [NUM_WAYS-2:0] plru_next;
  logic [NUM_LINE-1:0] hit_line, merged;
  logic hit, lookup_hit, fill_done;
  assign set = req_line[NUM_INDEX-1:0];
  assign req_tag = req_line[NUM_INDEX +: NUM_TAG];
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    plru_way = '0;
    // Descending scan so the lowest-index match wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid[set][w] && tags[set][w] == req_tag;
      hit_way = hit_vec[w] ? WW'(w) : hit_way;
      inv_way = !valid[set][w] ? WW'(w) : inv_way;
      plru_way = plru_oh[w] ? WW'(w) : plru_way;
    end
  end
  assign hit = |hit_vec;
  assign pick_way = &valid[set] ? plru_way : inv_way;
  assign hit_line = lines[set][hit_way];
  assign lookup_hit = state == LOOKUP && hit;
  assign fill_done = state == FILL && bus.pmem_resp;
  assign merged = NUM_LINE'(byte_merge(L2_MAX_LINE'(hit_line), L2_MAX_LINE'(req_wdata),
                                       L2_MAX_BYTES'(req_be)));
  l2_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits(plru[set]),
    .access_way(hit_way),
    .load(lookup_hit),
    .next_bits(plru_next),
    .victim(plru_oh)
  );
  always_comb begin
    next_state = state;
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    bus.pmem_read = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata = '0;
    case (state)
      IDLE: next_state = (bus.mem_read || bus.mem_write) ? LOOKUP : IDLE;
      LOOKUP: begin
        bus.mem_resp = hit;
        bus.mem_rdata = hit ? hit_line : '0;
        next_state = hit ? IDLE : (valid[set][pick_way] && dirty[set][pick_way]) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        bus.pmem_address = {tags[set][victim_way], set, {NUM_OFFSET{1'b0}}};
        bus.pmem_wdata = lines[set][victim_way];
        next_state = bus.pmem_resp ? FILL : WRITEBACK;
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        bus.pmem_address = {req_line, {NUM_OFFSET{1'b0}}};
        next_state = bus.pmem_resp ? LOOKUP : FILL;
      end
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      plru <= '0;
      refill <= 1'b0;
      victim_way <= '0;
    end else begin
      state <= next_state;
      refill <= fill_done;
      if (state == LOOKUP && !hit) victim_way <= pick_way;
      if (lookup_hit) plru[set] <= plru_next;
      if (lookup_hit && req_write) dirty[set][hit_way] <= 1'b1;
      if (fill_done) begin
        valid[set][victim_way] <= 1'b1;
        dirty[set][victim_way] <= 1'b0;
      end
    end
  end
  // Datapath storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == IDLE && (bus.mem_read || bus.mem_write)) begin
      req_line <= bus.mem_address[31:NUM_OFFSET];
      req_wdata <= bus.mem_wdata;
      req_be <= bus.mem_byte_enable;
      req_write <= bus.mem_write;
    end
    if (fill_done) begin
      tags[set][victim_way] <= req_tag;
      lines[set][victim_way] <= bus.pmem_rdata;
    end else if (lookup_hit && req_write) begin
      lines[set][hit_way] <= merged;
    end
  end
`ifdef L2_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
      miss_count <= '0;
      wb_count <= '0;
    end else begin
      if (lookup_hit && !refill) hit_count <= hit_count + 32'd1;
      if (state == LOOKUP && !hit) miss_count <= miss_count + 32'd1;
      if (state == WRITEBACK && bus.pmem_resp) wb_count <= wb_count + 32'd1;
    end
  end
`else
  assign hit_count = '0;
  assign miss_count = '0;
  assign wb_count = '0;
`endif
endmodule
